// File: rtl/hdb3_encoder.sv
`timescale 1ns/1ps
// hdb3_encoder
// Transmit-side HDB3 line encoder. One NRZ bit in and one ternary symbol
// out per enabled clock, with a fixed latency of four enabled cycles.
// Each run of four zeros becomes 000V or B00V so that the number of marks
// between violations is always odd. Mark polarity alternates.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         clock enable; every register holds while low
//   data_in    NRZ bit, sampled on a rising clk edge when en=1
//   hdb3_code  registered ternary output: 00 = zero, 01 = +1, 11 = -1
//
// Parameters
//   INIT_LAST_POS  reset value of the last-pulse polarity flag
//                  (0 = previous pulse taken as negative, so the first
//                  mark after reset is +1)
module hdb3_encoder #(
  parameter logic INIT_LAST_POS = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       data_in,
  output logic [1:0] hdb3_code
);

  localparam int PIPE_DEPTH = 4;

  typedef enum logic [1:0] {
    SYM_ZERO = 2'd0,
    SYM_ONE  = 2'd1,
    SYM_B    = 2'd2,
    SYM_V    = 2'd3
  } sym_t;

  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_POS  = 2'b01;
  localparam logic [1:0] CODE_NEG  = 2'b11;

  // Stage A: zero counting and violation insertion
  sym_t       sym_in;
  logic [1:0] zcnt_reg, zcnt_next;
  logic       parity_reg, parity_next;   // 1 = odd number of marks since last V
  logic       insert_b;

  // Stage B: symbol pipe, index 0 is the newest entry
  sym_t       pipe_reg  [PIPE_DEPTH];
  sym_t       pipe_next [PIPE_DEPTH];

  // Stage C: polarity assignment
  logic       last_pos_reg, last_pos_next;
  logic [1:0] code_reg, code_next;

  // -------------------------------------------------------------------------
  // Stage A
  // -------------------------------------------------------------------------
  always_comb begin
    sym_in      = SYM_ZERO;
    zcnt_next   = zcnt_reg;
    parity_next = parity_reg;
    if (data_in) begin
      sym_in      = SYM_ONE;
      zcnt_next   = 2'd0;
      parity_next = ~parity_reg;
    end else if (zcnt_reg == 2'd3) begin
      // Fourth consecutive zero becomes the violation; parity restarts.
      sym_in      = SYM_V;
      zcnt_next   = 2'd0;
      parity_next = 1'b0;
    end else begin
      zcnt_next   = zcnt_reg + 2'd1;
    end
  end

  // An even mark count before this V means the run needs a balancing B.
  // The pre-update parity is used, so the V itself is never counted.
  assign insert_b = (sym_in == SYM_V) && !parity_reg;

  // -------------------------------------------------------------------------
  // Stage B: shift chain. When the V enters s0, s2 holds the first zero of
  // the same run, which is exactly the slot that must become B.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_next[gi] = sym_in;
      end else if (gi == PIPE_DEPTH - 1) begin : g_tail
        assign pipe_next[gi] = insert_b ? SYM_B : pipe_reg[gi-1];
      end else begin : g_mid
        assign pipe_next[gi] = pipe_reg[gi-1];
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Stage C: marks and B alternate polarity, V repeats the last polarity.
  // -------------------------------------------------------------------------
  always_comb begin
    code_next     = CODE_ZERO;
    last_pos_next = last_pos_reg;
    case (pipe_reg[PIPE_DEPTH-1])
      SYM_ONE, SYM_B: begin
        code_next     = last_pos_reg ? CODE_NEG : CODE_POS;
        last_pos_next = ~last_pos_reg;
      end
      SYM_V: begin
        code_next     = last_pos_reg ? CODE_POS : CODE_NEG;
      end
      default: begin
        code_next     = CODE_ZERO;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zcnt_reg     <= 2'd0;
      parity_reg   <= 1'b0;
      last_pos_reg <= INIT_LAST_POS;
      code_reg     <= CODE_ZERO;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_reg[i] <= SYM_ZERO;
      end
    end else if (en) begin
      zcnt_reg     <= zcnt_next;
      parity_reg   <= parity_next;
      last_pos_reg <= last_pos_next;
      code_reg     <= code_next;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_reg[i] <= pipe_next[i];
      end
    end
  end

  assign hdb3_code = code_reg;

endmodule

// File: tb/tb_hdb3_encoder.sv
`timescale 1ns/1ps
// Testbench for hdb3_encoder: directed vector tables, enable toggling,
// asynchronous reset mid-run, and a long random stream checked against a
// substitution/polarity reference model and an independent decoder.
module tb_hdb3_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       data_in = 1'b0;
  logic [1:0] hdb3_code;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] C_Z = 2'b00;
  localparam logic [1:0] C_P = 2'b01;
  localparam logic [1:0] C_N = 2'b11;
  localparam int N = 10000;

  hdb3_encoder #(.INIT_LAST_POS(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .data_in   (data_in),
    .hdb3_code (hdb3_code)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Comparison helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic check_ok(input string name, input bit ok, input int idx);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got 0, required 1 (index %0d)", name, idx);
    end
  endtask

  task automatic step(input bit e, input bit d);
    en      = e;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    en      = 1'b0;
    data_in = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", hdb3_code, C_Z);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Vector tables
  // ---------------------------------------------------------------------------
  typedef struct {
    int         pat;
    bit         do_rst;
    bit         din;
    logic [1:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int pat, input bit r, input bit d, input logic [1:0] x);
    vec_t v;
    v.pat = pat; v.do_rst = r; v.din = d; v.exp = x;
    vecs.push_back(v);
  endtask

  bit         p1_d [10] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  logic [1:0] p1_x [10] = '{C_Z, C_Z, C_Z, C_Z, C_P, C_Z, C_Z, C_Z, C_P, C_N};
  logic [1:0] p2_rep [8] = '{C_P, C_Z, C_Z, C_P, C_N, C_Z, C_Z, C_N};
  bit         p3_d [11] = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  logic [1:0] p3_x [11] = '{C_Z, C_Z, C_Z, C_Z, C_P, C_N, C_P, C_Z, C_Z, C_P, C_N};

  // Random-stream storage
  bit         rbits [N+4];
  int         rsym  [N+4];   // 0 zero, 1 mark, 2 B, 3 V
  int         rpol  [N+4];
  logic [1:0] rexp  [N+4];
  int         rx    [N];
  bit         dec   [N];

  int         k, guard, ones, zrun, last, last_pol, pulses, last_v, zr;
  bit         e, d;
  logic [1:0] prev, expv;

  initial begin
    // ---- Fill tables ----
    for (int i = 0; i < 10; i++) add_vec(1, i == 0, p1_d[i], p1_x[i]);
    for (int i = 0; i < 20; i++) add_vec(2, i == 0, 1'b0, (i < 4) ? C_Z : p2_rep[(i-4)%8]);
    for (int i = 0; i < 11; i++) add_vec(3, i == 0, p3_d[i], p3_x[i]);

    // ---- Table-driven directed patterns ----
    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      step(1'b1, vecs[i].din);
      $display("vec %0d pat %0d din=%b code=%b exp=%b",
               i, vecs[i].pat, vecs[i].din, hdb3_code, vecs[i].exp);
      check($sformatf("table_p%0d_v%0d", vecs[i].pat, i), hdb3_code, vecs[i].exp);
    end

    // ---- Pattern 1 with random enable gaps ----
    do_reset();
    k = 0; guard = 0; prev = C_Z;
    while (k < 10 && guard < 200) begin
      e = ($urandom_range(0, 2) != 0);
      d = e ? p1_d[k] : 1'($urandom_range(0, 1));
      step(e, d);
      if (e) begin
        check($sformatf("en_toggle_k%0d", k), hdb3_code, p1_x[k]);
        prev = p1_x[k];
        k++;
      end else begin
        check("en_hold", hdb3_code, prev);
      end
      guard++;
    end
    check_ok("en_toggle_done", k == 10, k);
    $display("en-toggle pattern done after %0d cycles", guard);

    // ---- Asynchronous reset in the middle of a zero run ----
    do_reset();
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("pre_async_rst", hdb3_code, C_P);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_immediate", hdb3_code, C_Z);
    step(1'b1, 1'b0);
    check("async_rst_held", hdb3_code, C_Z);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      check($sformatf("post_rst_c%0d", i), hdb3_code, (i < 4) ? C_Z : p2_rep[i-4]);
    end
    $display("async reset sequence done");

    // ---- Random stream: reference model ----
    for (int i = 0; i < N + 4; i++) rbits[i] = 1'($urandom_range(0, 1));
    ones = 0; zrun = 0;
    for (int i = 0; i < N + 4; i++) begin
      if (rbits[i]) begin
        rsym[i] = 1; ones++; zrun = 0;
      end else begin
        rsym[i] = 0; zrun++;
        if (zrun == 4) begin
          if (ones % 2 == 0) rsym[i-3] = 2;
          rsym[i] = 3; ones = 0; zrun = 0;
        end
      end
    end
    last = -1;
    for (int i = 0; i < N + 4; i++) begin
      case (rsym[i])
        1, 2:    begin last = -last; rpol[i] = last; end
        3:       rpol[i] = last;
        default: rpol[i] = 0;
      endcase
      rexp[i] = (rpol[i] > 0) ? C_P : ((rpol[i] < 0) ? C_N : C_Z);
    end

    // ---- Random stream: drive and compare ----
    do_reset();
    k = 0; guard = 0; prev = C_Z;
    while (k < N + 4 && guard < 60000) begin
      e = ($urandom_range(0, 4) != 0);
      d = e ? rbits[k] : 1'($urandom_range(0, 1));
      step(e, d);
      if (e) begin
        expv = (k < 4) ? C_Z : rexp[k-4];
        check("rand_code", hdb3_code, expv);
        if (k >= 4) begin
          case (hdb3_code)
            2'b01:   rx[k-4] = 1;
            2'b11:   rx[k-4] = -1;
            2'b00:   rx[k-4] = 0;
            default: rx[k-4] = 2;
          endcase
        end
        prev = expv;
        k++;
      end else begin
        check("rand_hold", hdb3_code, prev);
      end
      guard++;
    end
    check_ok("rand_done", k == N + 4, k);

    // ---- Independent decode and line invariants ----
    last_pol = -1; pulses = 0; last_v = 0; zr = 0;
    for (int i = 0; i < N; i++) begin
      check_ok("no_code_10", rx[i] != 2, i);
      zr = (rx[i] == 0) ? zr + 1 : 0;
      check_ok("zero_run_max3", zr <= 3, i);
      if (rx[i] == 0 || rx[i] == 2) begin
        dec[i] = 1'b0;
      end else if (rx[i] == last_pol) begin
        dec[i] = 1'b0;
        if (i >= 3) dec[i-3] = 1'b0;
        check_ok("odd_pulses", (pulses % 2) == 1, i);
        if (last_v != 0) check_ok("v_alternate", rx[i] != last_v, i);
        last_v = rx[i];
        pulses = 0;
      end else begin
        dec[i] = 1'b1;
        last_pol = rx[i];
        pulses++;
      end
    end
    for (int i = 0; i < N - 4; i++) begin
      check_ok("decode_bit", dec[i] == rbits[i], i);
    end
    $display("random stream of %0d bits done in %0d cycles", N, guard);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hdb3_encoder.md
Name: hdb3_encoder

Overview:
Transmit-side HDB3 line encoder. Each enabled clock it accepts one NRZ binary bit and emits one 2-bit ternary symbol. It substitutes each run of four zeros with 000V or B00V and alternates mark polarity. Its output feeds the line interface and the receive-side B/V-removal and decoder path, for loopback.

Parameters:
- INIT_LAST_POS, 1'b0, reset value of the last-pulse-polarity flag. 0 = last pulse treated as negative, so the first pulse after reset is +1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  clock enable; pipeline advances only when 1
- data_in  input  1  NRZ binary bit, sampled on rising clk when en=1
- hdb3_code  output  2  ternary symbol: 2'b00 = zero, 2'b01 = +1, 2'b11 = -1; 2'b10 is never driven

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n low asynchronously clears all state: symbol pipe = ZERO, zero counter = 0, parity = even, last_pos = INIT_LAST_POS, hdb3_code = 2'b00.
  - Reset asserted mid-run discards all in-flight symbols; no partial substitution is emitted afterwards.
- en=0: every register holds, including hdb3_code. data_in is ignored.
- Internal symbol alphabet: ZERO, ONE, B, V.
- Stage A, V insertion (combinational on data_in, registered into s0):
  - zcnt is a 2-bit count of consecutive input zeros.
  - data_in=1 -> symbol ONE; zcnt <= 0; parity toggles.
  - data_in=0 and zcnt<3 -> symbol ZERO; zcnt increments.
  - data_in=0 and zcnt==3 -> symbol V; zcnt <= 0; parity <= even.
  - parity counts ONE symbols entering s0 since the last V. Inserted B pulses are not counted here.
- Stage B, 4-deep symbol pipe s0..s3 (s0 newest), shifts each enabled cycle.
  - If the symbol entering s0 is V and parity is even (evaluated before the update in the same cycle), the ZERO shifting from s2 into s3 is replaced by B. That zero is the first zero of the run.
  - Otherwise s2 shifts into s3 unchanged.
- Stage C, polarity (registered output from s3):
  - ZERO -> 2'b00; last_pos unchanged.
  - ONE or B -> polarity opposite to last_pos (+1 if last_pos=0); last_pos toggles.
  - V -> same polarity as last_pos; last_pos unchanged.
- Latency: a bit sampled at enabled edge k appears on hdb3_code after enabled edge k+4. The first 4 enabled outputs after reset are 2'b00. Pipe reset zeros are not counted by zcnt.
- Invariants:
  - The number of non-zero B/ONE pulses between consecutive V's is odd.
  - Consecutive V's alternate polarity.
  - Zero runs on the output never exceed 3.
- hdb3_code is registered with no combinational path from inputs. Stream is continuous, with no framing.

Test Plan:
- Reset, then en=1 with data_in=1,0,0,0,0,1 -> after 4 cycles of 00, hdb3_code = 01,00,00,00,01,11 (000V, V=+1 matches the prior mark).
- Reset, then data_in held 0 for 16 bits -> after latency, output repeats 01,00,00,01,11,00,00,11 (B00V with alternating V polarity).
- Reset, then data_in=1,1,0,0,0,0,1 -> 01,11,01,00,00,01,11 (even parity, so B00V is inserted).
- Random 10k-bit stream -> decode through the B/V-removal path plus AMI-to-binary reference. Required: bit-exact match at 4-cycle latency, no 2'b10 output, no run of more than 3 zeros, V-polarity and odd-pulse invariants hold.
- en toggled randomly during pattern 1 -> output sequence identical to en=1 run when counted in enabled cycles; hdb3_code stable while en=0.
- Assert rst_n low asynchronously midway through a 0000 run -> hdb3_code = 00 immediately. After release, the first zero run is encoded B00V with first mark +1.
